// File: rtl/vend_dispenser.sv
// Dispenser mechanism: queues request pulses, fires one actuator at a time for
// ACT_CYCLES followed by GAP_CYCLES idle, and tracks stock and hopper levels.
module vend_dispenser #(
  parameter int ACT_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 5,
  parameter int STOCK_INIT = 8,
  parameter int COIN_INIT  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic drop_water,
  input  logic drop_coke,
  input  logic drop_coffee,
  input  logic change5,
  input  logic change10,
  input  logic refill,
  output logic motor_water,
  output logic motor_coke,
  output logic motor_coffee,
  output logic eject5,
  output logic eject10,
  output logic sold_out_water,
  output logic sold_out_coke,
  output logic sold_out_coffee,
  output logic empty5,
  output logic empty10,
  output logic busy,
  output logic fault,
  output logic err_multi,
  output logic err_ovf
);

  localparam int TMR_MAX = (ACT_CYCLES > GAP_CYCLES) ? ACT_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACT, GAP} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [4:0]       act_q, act_d;
  logic             fault_q, fault_d;

  // Resource slots, index = request code - 1: water, coke, coffee, c10, c5
  logic [CNT_W-1:0] cnt_q [5];
  logic [4:0]       dec;
  logic [4:0]       nz;

  logic [4:0]       req_vec;
  logic [2:0]       req_code;
  logic             req_any, req_multi;

  logic [2:0]       fifo_mem [4];
  logic [1:0]       wr_ptr, rd_ptr;
  logic [2:0]       fifo_cnt;
  logic             fifo_empty, push, pop, ovf;
  logic [2:0]       head;
  logic [4:0]       head_sel;
  logic             head_avail;

  // Priority capture of the request inputs (water highest, change5 lowest)
  always_comb begin
    req_vec   = {change5, change10, drop_coffee, drop_coke, drop_water};
    req_any   = |req_vec;
    req_multi = (req_vec & (req_vec - 5'd1)) != '0;
    req_code  = 3'd0;
    if (drop_water)       req_code = 3'd1;
    else if (drop_coke)   req_code = 3'd2;
    else if (drop_coffee) req_code = 3'd3;
    else if (change10)    req_code = 3'd4;
    else if (change5)     req_code = 3'd5;
  end

  // Head-of-queue decode and resource availability
  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    head       = fifo_mem[rd_ptr];
    case (head)
      3'd1:    head_sel = 5'b00001;
      3'd2:    head_sel = 5'b00010;
      3'd3:    head_sel = 5'b00100;
      3'd4:    head_sel = 5'b01000;
      3'd5:    head_sel = 5'b10000;
      default: head_sel = '0;
    endcase
    for (int unsigned i = 0; i < 5; i++) nz[i] = (cnt_q[i] != '0);
    head_avail = |(head_sel & nz);
  end

  // A full queue still accepts a push when the same cycle pops
  always_comb begin
    push = req_any && ((fifo_cnt != 3'd4) || pop);
    ovf  = req_any && (fifo_cnt == 3'd4) && !pop;
  end

  // FSM next-state, actuator and pop/decrement decisions
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    act_d   = act_q;
    fault_d = 1'b0;
    pop     = 1'b0;
    dec     = '0;
    case (state_q)
      IDLE: begin
        act_d = '0;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_avail) begin
            dec     = head_sel;
            act_d   = head_sel;
            tmr_d   = TMR_W'(ACT_CYCLES);
            state_d = ACT;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      ACT: begin
        if (tmr_q == TMR_W'(1)) begin
          act_d   = '0;
          tmr_d   = TMR_W'(GAP_CYCLES);
          state_d = GAP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      GAP: begin
        if (tmr_q == TMR_W'(1)) state_d = IDLE;
        else                    tmr_d   = tmr_q - TMR_W'(1);
      end
      default: begin
        act_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      act_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      act_q   <= act_d;
      fault_q <= fault_d;
    end
  end

  // Request FIFO pointers/occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      err_multi <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 3'd1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 3'd1;
      if (req_multi) err_multi <= 1'b1;
      if (ovf)       err_ovf   <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_code;
  end

  // Stock/hopper counters; refill overrides a same-cycle decrement
  always_ff @(posedge clk) begin
    if (rst || refill) begin
      for (int unsigned i = 0; i < 5; i++)
        cnt_q[i] <= (i < 3) ? CNT_W'(STOCK_INIT) : CNT_W'(COIN_INIT);
    end else begin
      for (int unsigned i = 0; i < 5; i++)
        if (dec[i] && nz[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
    end
  end

  // Output mapping
  always_comb begin
    motor_water     = act_q[0];
    motor_coke      = act_q[1];
    motor_coffee    = act_q[2];
    eject10         = act_q[3];
    eject5          = act_q[4];
    sold_out_water  = !nz[0];
    sold_out_coke   = !nz[1];
    sold_out_coffee = !nz[2];
    empty10         = !nz[3];
    empty5          = !nz[4];
    busy            = (state_q != IDLE) || !fifo_empty;
    fault           = fault_q;
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: directed scenarios followed by random traffic,
// every cycle compared against a timeline-based reference model.
module tb_vend_dispenser;

  localparam int ACT = 4;
  localparam int GAP = 2;
  localparam int STOCK = 8;
  localparam int COIN = 20;

  logic clk = 1'b0;
  logic rst, drop_water, drop_coke, drop_coffee, change5, change10, refill;
  logic motor_water, motor_coke, motor_coffee, eject5, eject10;
  logic sold_out_water, sold_out_coke, sold_out_coffee, empty5, empty10;
  logic busy, fault, err_multi, err_ovf;

  vend_dispenser #(
    .ACT_CYCLES(ACT), .GAP_CYCLES(GAP), .CNT_W(5), .STOCK_INIT(STOCK), .COIN_INIT(COIN)
  ) dut (
    .clk(clk), .rst(rst),
    .drop_water(drop_water), .drop_coke(drop_coke), .drop_coffee(drop_coffee),
    .change5(change5), .change10(change10), .refill(refill),
    .motor_water(motor_water), .motor_coke(motor_coke), .motor_coffee(motor_coffee),
    .eject5(eject5), .eject10(eject10),
    .sold_out_water(sold_out_water), .sold_out_coke(sold_out_coke),
    .sold_out_coffee(sold_out_coffee), .empty5(empty5), .empty10(empty10),
    .busy(busy), .fault(fault), .err_multi(err_multi), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: resource index 0..4 = water, coke, coffee, c10, c5
  // (also the capture priority order). Server timing kept as cycle stamps.
  int m_q[$];
  int m_cnt[5];
  int m_next_pop;   // first cycle in which the server may pop again
  int m_rise;       // cycle the current actuator rose
  int m_code;
  int m_fault_at;
  bit m_multi, m_ovf;

  function automatic void m_reset();
    m_q.delete();
    for (int i = 0; i < 5; i++) m_cnt[i] = (i < 3) ? STOCK : COIN;
    m_next_pop = 0;
    m_rise     = -1000;
    m_code     = 0;
    m_fault_at = -1;
    m_multi    = 1'b0;
    m_ovf      = 1'b0;
  endfunction

  // Advance the model from cycle cyc to cyc+1 given this cycle's inputs
  function automatic void m_advance(input logic [4:0] r, input logic rf, input logic rs);
    int n;
    int c;
    if (rs) begin
      m_reset();
      return;
    end
    if (cyc >= m_next_pop && m_q.size() > 0) begin
      c = m_q.pop_front();
      if (m_cnt[c] > 0) begin
        m_cnt[c]--;
        m_rise     = cyc + 1;
        m_code     = c;
        m_next_pop = cyc + 1 + ACT + GAP;
      end else begin
        m_fault_at = cyc + 1;
      end
    end
    n = 0;
    c = -1;
    for (int i = 4; i >= 0; i--) if (r[i]) begin n++; c = i; end
    if (n >= 2) m_multi = 1'b1;
    if (n > 0) begin
      if (m_q.size() < 4) m_q.push_back(c);
      else m_ovf = 1'b1;
    end
    if (rf) for (int i = 0; i < 5; i++) m_cnt[i] = (i < 3) ? STOCK : COIN;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0] e_act, e_flags;
    e_act = '0;
    if (cyc >= m_rise && cyc < m_rise + ACT) e_act[m_code] = 1'b1;
    for (int i = 0; i < 5; i++) e_flags[i] = (m_cnt[i] == 0);
    chk("actuators", {3'b0, eject5, eject10, motor_coffee, motor_coke, motor_water}, {3'b0, e_act});
    chk("flags", {3'b0, empty5, empty10, sold_out_coffee, sold_out_coke, sold_out_water}, {3'b0, e_flags});
    chk("fault", {7'b0, fault}, {7'b0, (m_fault_at == cyc)});
    chk("busy", {7'b0, busy}, {7'b0, (cyc < m_next_pop) || (m_q.size() > 0)});
    chk("err_multi", {7'b0, err_multi}, {7'b0, m_multi});
    chk("err_ovf", {7'b0, err_ovf}, {7'b0, m_ovf});
  endtask

  // One clock cycle: drive inputs, advance model, sample at the next negedge
  task automatic step(input logic [4:0] r, input logic rf, input logic rs);
    {change5, change10, drop_coffee, drop_coke, drop_water} = r;
    refill = rf;
    rst    = rs;
    m_advance(r, rf, rs);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] r;
    logic       rf, rs;
    rst = 1'b1; refill = 1'b0;
    {change5, change10, drop_coffee, drop_coke, drop_water} = '0;
    m_reset();
    @(negedge clk);
    step(5'b0, 1'b0, 1'b1);
    step(5'b0, 1'b0, 1'b1);
    idle(3);

    // single water request
    step(5'b00001, 1'b0, 1'b0);
    idle(10);
    // change10 then change5 on consecutive cycles
    step(5'b01000, 1'b0, 1'b0);
    step(5'b10000, 1'b0, 1'b0);
    idle(16);
    // nine spaced coke requests: eight serves then a fault, then refill
    for (int k = 0; k < 9; k++) begin
      step(5'b00010, 1'b0, 1'b0);
      idle(8);
    end
    step(5'b0, 1'b1, 1'b0);
    idle(3);
    // six back-to-back coffee requests overflow the queue
    for (int k = 0; k < 6; k++) step(5'b00100, 1'b0, 1'b0);
    idle(40);
    // collision of water and change5
    step(5'b10001, 1'b0, 1'b0);
    idle(10);
    // reset while the coffee motor is running
    step(5'b00100, 1'b0, 1'b0);
    idle(3);
    step(5'b0, 1'b0, 1'b1);
    idle(4);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = '0;
      if ($urandom_range(0, 39) == 0) r = 5'($urandom_range(0, 31));
      else if ($urandom_range(0, 4) == 0) r[$urandom_range(0, 4)] = 1'b1;
      rf = ($urandom_range(0, 699) == 0);
      rs = ($urandom_range(0, 1499) == 0);
      step(r, rf, rs);
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
